// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter: round-robin arbiter for eight requesters sharing one
// 8:1 selection datapath, presented on a single valid/ready output channel.
// A requester is granted, its word is routed through the 8:1 selection and
// it is acknowledged on the cycle the word transfers.
// Optional build macro ARB_LOCK_EN adds a 'lock' input for burst locking:
// while lock is high and the granted requester keeps requesting, a transfer
// leaves the grant on that requester and does not advance the priority.
module rr_mux8_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      req,
  input  logic [8*DW-1:0] din,
  input  logic            out_ready,
`ifdef ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      sel,
  output logic [7:0]      ack
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_sel;
  logic [2:0] r_ptr;
  logic       r_valid;

  logic       w_xfer;
  logic [7:0] w_sel_oh;
  logic [2:0] w_next_ptr;
  logic [2:0] w_scan_ptr;
  logic [7:0] w_scan_req;
  logic       w_found;
  logic [2:0] w_winner;
  logic       w_lock_hold;

  assign w_xfer     = r_valid & out_ready;
  assign w_sel_oh   = 8'b1 << r_sel;
  assign w_next_ptr = r_sel + 3'd1;

  // While idle the scan starts at the stored priority pointer over all
  // requests; while granted it looks ahead to the post-transfer pointer and
  // excludes the current winner, so a transfer can hand over in one cycle.
  assign w_scan_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;
  assign w_scan_req = (r_state == GRANT) ? (req & ~w_sel_oh) : req;

`ifdef ARB_LOCK_EN
  assign w_lock_hold = lock & req[r_sel];
`else
  assign w_lock_hold = 1'b0;
`endif

  // Circular priority scan: first active request at or after the start index.
  always_comb begin
    w_found  = 1'b0;
    w_winner = w_scan_ptr;
    for (int i = 0; i < 8; i++) begin
      if (!w_found && w_scan_req[w_scan_ptr + 3'(i)]) begin
        w_found  = 1'b1;
        w_winner = w_scan_ptr + 3'(i);
      end
    end
  end

  // Grant state machine: select, priority pointer and valid are all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel   <= w_winner;
            r_valid <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            if (!w_lock_hold) begin
              r_ptr <= w_next_ptr;
              if (w_found) begin
                r_sel <= w_winner;
              end else if (!req[r_sel]) begin
                r_valid <= 1'b0;
                r_state <= IDLE;
              end
            end
          end else if (!req[r_sel]) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_valid;
  assign out_data  = din[int'(r_sel)*DW +: DW];
  assign ack       = w_xfer ? w_sel_oh : 8'h00;

endmodule
